// File: rtl/lcd_read_fsm_if.sv
// Bus bundle between a read requester and the HD44780 4-bit read engine,
// carrying both the request/response handshake and the LCD pin-side lines.
interface lcd_read_fsm_if;
    // Request/response: start is a one-cycle (or held) request sampled only
    // while idle; rd_valid is a one-cycle strobe qualifying rd_data and
    // poll_timeout; busy is high from accept until the engine is idle again.
    logic       start;
    logic       rs_sel;
    logic       busy;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       poll_timeout;
    logic [3:0] SF_D_in;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       bus_req;

    modport master (
        output start, rs_sel, SF_D_in,
        input  busy, rd_data, rd_valid, poll_timeout,
        input  LCD_E, LCD_RS, LCD_RW, bus_req
    );

    modport slave (
        input  start, rs_sel, SF_D_in,
        output busy, rd_data, rd_valid, poll_timeout,
        output LCD_E, LCD_RS, LCD_RW, bus_req
    );
endinterface

// File: rtl/lcd_read_fsm.sv
// HD44780 4-bit read engine: one byte as two E-pulsed nibble reads, high first.
// Optional busy-flag re-polling is enabled with the LCD_BUSY_POLL_EN macro.
module lcd_read_fsm #(
    parameter int SETUP_CYC      = 2,
    parameter int E_HIGH_CYC     = 12,
    parameter int HOLD_CYC       = 1,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int POLL_MAX       = 255
) (
    input  logic          clk,
    input  logic          reset,
    lcd_read_fsm_if.slave bus,
    output logic [3:0]    dbg_state
);

    typedef enum logic [3:0] {
        IDLE, SETUP_HI, E_HI, HOLD_HI, GAP,
        SETUP_LO, E_LO, HOLD_LO, DONE, POLL_WAIT
    } state_t;

    // The poll counter is 8 bits wide, so the re-read limit must fit in it.
    if (POLL_MAX < 1 || POLL_MAX > 255) begin : g_poll_max_range
        $error("POLL_MAX must be in 1..255");
    end

    state_t      state;
    logic [11:0] cnt;
    logic [11:0] limit;
    logic        step_done;
    logic        rs_lat;
    logic        active;
    logic [7:0]  rd_data;

`ifdef LCD_BUSY_POLL_EN
    logic [7:0]  poll_cnt;
    logic        poll_to;
`endif

    always_comb begin
        limit = 12'd1;
        case (state)
            SETUP_HI, SETUP_LO: limit = 12'(SETUP_CYC);
            E_HI, E_LO:         limit = 12'(E_HIGH_CYC);
            HOLD_HI, HOLD_LO:   limit = 12'(HOLD_CYC);
            GAP, POLL_WAIT:     limit = 12'(NIBBLE_GAP_CYC);
            default:            limit = 12'd1;
        endcase
    end

    assign step_done = (cnt == limit - 12'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 12'd0;
            rs_lat  <= 1'b0;
            rd_data <= 8'h00;
`ifdef LCD_BUSY_POLL_EN
            poll_cnt <= 8'd0;
            poll_to  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SETUP_HI;
                        cnt    <= 12'd0;
                        rs_lat <= bus.rs_sel;
`ifdef LCD_BUSY_POLL_EN
                        poll_cnt <= 8'd0;
                        poll_to  <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= 12'd0;
                end
                default: begin
                    if (!step_done) begin
                        cnt <= cnt + 12'd1;
                    end else begin
                        cnt <= 12'd0;
                        case (state)
                            SETUP_HI: state <= E_HI;
                            E_HI: begin
                                // Sample on the final E-high cycle so the
                                // LCD's output delay has fully elapsed.
                                state        <= HOLD_HI;
                                rd_data[7:4] <= bus.SF_D_in;
                            end
                            HOLD_HI:  state <= GAP;
                            GAP:      state <= SETUP_LO;
                            SETUP_LO: state <= E_LO;
                            E_LO: begin
                                state        <= HOLD_LO;
                                rd_data[3:0] <= bus.SF_D_in;
                            end
                            HOLD_LO: begin
`ifdef LCD_BUSY_POLL_EN
                                // BF (bit 7) set on a status read: wait a gap
                                // and re-read, until the re-read budget runs out.
                                if (!rs_lat && rd_data[7]) begin
                                    if (poll_cnt < 8'(POLL_MAX)) begin
                                        state    <= POLL_WAIT;
                                        poll_cnt <= poll_cnt + 8'd1;
                                    end else begin
                                        state   <= DONE;
                                        poll_to <= 1'b1;
                                    end
                                end else begin
                                    state <= DONE;
                                end
`else
                                state <= DONE;
`endif
                            end
                            POLL_WAIT: state <= SETUP_HI;
                            default:   state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // Moore outputs straight from the registered state: no extra latency.
    assign active       = (state != IDLE) && (state != DONE);
    assign bus.LCD_E    = (state == E_HI) || (state == E_LO);
    assign bus.LCD_RW   = active;
    assign bus.LCD_RS   = active && rs_lat;
    assign bus.bus_req  = active;
    assign bus.busy     = (state != IDLE);
    assign bus.rd_valid = (state == DONE);
    assign bus.rd_data  = rd_data;
    assign dbg_state    = state;

`ifdef LCD_BUSY_POLL_EN
    assign bus.poll_timeout = poll_to;
`else
    assign bus.poll_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Self-checking bench for lcd_read_fsm: nibble responder on the LCD side,
// scoreboard of {poll_timeout, rd_data} popped on every rd_valid strobe.
module tb_lcd_read_fsm;

    localparam int E_HIGH = 12;
    localparam int W      = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dbg_state;

    lcd_read_fsm_if bus();

    lcd_read_fsm #(.POLL_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   pulse_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // LCD responder: each E pulse consumes {early, last}; 'early' is driven
    // from the rising edge, 'last' only on the final E-high cycle.
    int         e_run = 0;
    logic [7:0] cur_pulse = 8'h00;
    always @(negedge clk) begin
        if (bus.LCD_E) begin
            if (e_run == 0) begin
                cur_pulse = (pulse_q.size() > 0) ? pulse_q.pop_front() : 8'h00;
                bus.SF_D_in = cur_pulse[7:4];
            end
            e_run++;
            if (e_run == E_HIGH) bus.SF_D_in = cur_pulse[3:0];
        end else begin
            e_run = 0;
        end
    end

    // Scoreboard monitor.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!reset && bus.rd_valid) begin
            check_eq("rd_valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("rd_valid_unexpected", {31'd0, bus.rd_valid}, 32'd0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check_eq("rd_result", {23'd0, bus.poll_timeout, bus.rd_data}, {23'd0, e});
            end
        end
        prev_valid = bus.rd_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic issue_start(input logic rs);
        @(negedge clk);
        bus.rs_sel = rs;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic timed_read(input logic rs, input logic [3:0] hi_early,
                              input logic [3:0] hi, input logic [3:0] lo);
        int   r1, r2, w1, w2, n_rise, v_k, idle_k, rw_bad;
        logic e_prev, rw_v, req_v;
        r1 = 0; r2 = 0; w1 = 0; w2 = 0; n_rise = 0; v_k = 0; idle_k = 0; rw_bad = 0;
        e_prev = 1'b0; rw_v = 1'b1; req_v = 1'b1;
        pulse_q.push_back({hi_early, hi});
        pulse_q.push_back({lo, lo});
        exp_q.push_back({1'b0, hi, lo});
        issue_start(rs);
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (bus.LCD_E && !e_prev) begin
                n_rise++;
                if (n_rise == 1) r1 = k;
                else if (n_rise == 2) r2 = k;
            end
            if (bus.LCD_E) begin
                if (n_rise == 1) w1++;
                else w2++;
            end
            if (bus.bus_req && (bus.LCD_RW !== 1'b1 || bus.LCD_RS !== rs)) rw_bad++;
            if (bus.rd_valid && v_k == 0) begin
                v_k   = k;
                rw_v  = bus.LCD_RW;
                req_v = bus.bus_req;
            end
            if (!bus.busy && idle_k == 0) idle_k = k;
            e_prev = bus.LCD_E;
        end
        check_eq("e1_rise_cycle", r1, 3);
        check_eq("e1_width", w1, E_HIGH);
        check_eq("e2_width", w2, E_HIGH);
        check_eq("e_low_between", r2 - (r1 + E_HIGH), 53);
        check_eq("rd_valid_cycle", v_k, 81);
        check_eq("idle_cycle", idle_k, 82);
        check_eq("rs_rw_during_bus_req", rw_bad, 0);
        check_eq("done_rw_req", {30'd0, rw_v, req_v}, 32'd0);
    endtask

    task automatic continuous_start();
        int   v_pos[$];
        logic e_prev;
        for (int i = 0; i < 6; i++) pulse_q.push_back(8'h99);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 8'h99});
        @(negedge clk);
        bus.rs_sel = 1'b1;
        bus.start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 246; k++) begin
            @(negedge clk);
            if (bus.rd_valid) v_pos.push_back(k);
            if (k == 246) begin
                check_eq("cont_idle_before_stop", {31'd0, bus.busy}, 32'd0);
                bus.start = 1'b0;
            end
        end
        check_eq("cont_valid_count", v_pos.size(), 3);
        for (int i = 0; i < v_pos.size() && i < 3; i++)
            check_eq($sformatf("cont_valid_pos%0d", i), v_pos[i], 81 + 82 * i);
        e_prev = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e_prev = e_prev | bus.busy;
        end
        check_eq("cont_no_extra_accept", {31'd0, e_prev}, 32'd0);
    endtask

    task automatic reset_mid_read();
        int n_valid, n_rise;
        logic e_prev;
        n_valid = 0; n_rise = 0; e_prev = 1'b0;
        pulse_q.push_back(8'hBB);
        issue_start(1'b1);
        for (int k = 1; k <= 5; k++) @(negedge clk);
        check_eq("pre_reset_e_high", {31'd0, bus.LCD_E}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_e", {31'd0, bus.LCD_E}, 32'd0);
        check_eq("rst_mid_state", {28'd0, dbg_state}, 32'd0);
        check_eq("rst_mid_rd_data", {24'd0, bus.rd_data}, 32'd0);
        check_eq("rst_mid_flags", {28'd0, bus.rd_valid, bus.busy, bus.bus_req, bus.LCD_RW}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.rd_valid) n_valid++;
            if (bus.LCD_E && !e_prev) n_rise++;
            e_prev = bus.LCD_E;
        end
        check_eq("rst_no_valid", n_valid, 0);
        check_eq("rst_no_restart", n_rise, 0);
    endtask

`ifdef LCD_BUSY_POLL_EN
    task automatic poll_read(input int n_bf, input logic [3:0] hi, input logic [3:0] lo,
                             input logic exp_to, input int exp_rises);
        int   n_rise, seen;
        logic e_prev;
        n_rise = 0; seen = 0; e_prev = 1'b0;
        for (int i = 0; i < n_bf; i++) begin
            pulse_q.push_back(8'h88);
            pulse_q.push_back(8'h00);
        end
        pulse_q.push_back({hi, hi});
        pulse_q.push_back({lo, lo});
        exp_q.push_back({exp_to, hi, lo});
        issue_start(1'b0);
        for (int k = 0; k < 4000 && seen == 0; k++) begin
            @(negedge clk);
            if (bus.LCD_E && !e_prev) n_rise++;
            e_prev = bus.LCD_E;
            if (bus.rd_valid) seen = 1;
        end
        check_eq("poll_completed", seen, 1);
        check_eq("poll_e_pulses", n_rise, exp_rises);
        @(negedge clk);
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        bus.start  = 1'b0;
        bus.rs_sel = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("reset_lcd_lines", {29'd0, bus.LCD_E, bus.LCD_RS, bus.LCD_RW}, 32'd0);
        check_eq("reset_bus_req_busy", {30'd0, bus.bus_req, bus.busy}, 32'd0);
        check_eq("reset_rd", {22'd0, bus.poll_timeout, bus.rd_valid, bus.rd_data}, 32'd0);
        check_eq("reset_state", {28'd0, dbg_state}, 32'd0);

        timed_read(1'b1, 4'hA, 4'hA, 4'h5);
        timed_read(1'b1, 4'h3, 4'hC, 4'h7);
        timed_read(1'b0, 4'h4, 4'h4, 4'h1);
        for (int i = 0; i < 3; i++) begin
            logic [3:0] h, l;
            h = 4'($urandom_range(0, 15));
            l = 4'($urandom_range(0, 15));
            timed_read(1'b1, h, h, l);
        end

        continuous_start();
        reset_mid_read();

`ifdef LCD_BUSY_POLL_EN
        poll_read(3, 4'h2, 4'h7, 1'b0, 8);
        poll_read(4, 4'h8, 4'h1, 1'b1, 10);
        timed_read(1'b1, 4'h6, 4'h6, 4'h9);
`endif

        repeat (5) @(negedge clk);
        check_eq("exp_q_drained", exp_q.size(), 0);
        check_eq("pulse_q_drained", pulse_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
